// File: rtl/scan_ctrl_pkg.sv
// Shared types and configuration helpers for the scan-chain unload controller.
package scan_ctrl_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        CAPTURE = 3'd1,
        SHIFT   = 3'd2,
        DRAIN   = 3'd3,
        FIN     = 3'd4
    } state_t;

    localparam int unsigned DEF_CHAIN_LEN = 64;
    localparam int unsigned DEF_WORD_W    = 8;

    // Number of output words needed to carry one full chain.
    function automatic int unsigned words_per_chain(input int unsigned chain_len,
                                                    input int unsigned word_w);
        return (word_w == 0) ? 0 : chain_len / word_w;
    endfunction

    // A chain must split into a whole, non-zero number of words.
    function automatic bit chain_len_ok(input int unsigned chain_len,
                                        input int unsigned word_w);
        return (word_w != 0) && (chain_len >= word_w) && ((chain_len % word_w) == 0);
    endfunction

endpackage

// File: rtl/scan_deser.sv
// LSB-first deserializer with a single-entry ready/valid holding register.
module scan_deser
    import scan_ctrl_pkg::*;
#(
    parameter int unsigned WORD_W = DEF_WORD_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr,
    input  logic              sample,
    input  logic              so,
    input  logic              ready,
    output logic [WORD_W-1:0] dout,
    output logic              dvalid,
    output logic              stall_c
);

    localparam int unsigned IDX_W    = (WORD_W > 1) ? $clog2(WORD_W) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORD_W - 1);

    logic [IDX_W-1:0]  bit_idx_q;
    logic [WORD_W-1:0] shreg_q;
    logic [WORD_W-1:0] word_c;
    logic              word_done_c;

    // New bits enter at the MSB so the first bit lands in bit 0 after a full word.
    assign word_c      = WORD_W'({so, shreg_q} >> 1);
    assign word_done_c = sample && (bit_idx_q == LAST_IDX);

    // Completing a word while the previous one is still held would overwrite it.
    assign stall_c = (bit_idx_q == LAST_IDX) && dvalid && !ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bit_idx_q <= '0;
            shreg_q   <= '0;
        end else if (clr) begin
            bit_idx_q <= '0;
            shreg_q   <= '0;
        end else if (sample) begin
            shreg_q   <= word_c;
            bit_idx_q <= (bit_idx_q == LAST_IDX) ? '0 : bit_idx_q + IDX_W'(1);
        end
    end

    // Accept and reload may coincide, giving one word per WORD_W cycles.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dout   <= '0;
            dvalid <= 1'b0;
        end else if (word_done_c) begin
            dout   <= word_c;
            dvalid <= 1'b1;
        end else if (dvalid && ready) begin
            dvalid <= 1'b0;
        end
    end

endmodule

// File: rtl/scan_unload_ctrl.sv
// Captures a scan-mux chain once and streams its contents out as words.
module scan_unload_ctrl
    import scan_ctrl_pkg::*;
#(
    parameter int unsigned CHAIN_LEN = DEF_CHAIN_LEN,
    parameter int unsigned WORD_W    = DEF_WORD_W,
    parameter int unsigned CNT_W     = $clog2(CHAIN_LEN + 1)
) (
    input  logic              CK,
    input  logic              RSTN,
    input  logic              START,
    input  logic              FILL,
    output logic              BUSY,
    output logic              SCAN_SD,
    output logic              SCAN_SP,
    output logic              SCAN_SI,
    input  logic              SCAN_SO,
    output logic [WORD_W-1:0] DOUT,
    output logic              DVALID,
    input  logic              DREADY,
    output logic              DONE
);

    localparam int unsigned NUM_WORDS = words_per_chain(CHAIN_LEN, WORD_W);
    localparam bit CFG_OK = chain_len_ok(CHAIN_LEN, WORD_W) && (NUM_WORDS >= 1)
                            && (CNT_W >= $clog2(CHAIN_LEN + 1));
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(CHAIN_LEN - 1);

    generate
        if (!CFG_OK) begin : g_cfg_check
            $error("scan_unload_ctrl: CHAIN_LEN must be a non-zero multiple of WORD_W");
        end
    endgenerate

    state_t           state_q, state_d;
    logic             fill_q, fill_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             busy_d, sd_d, si_d, done_d;
    logic             sp_c, sample_c, clr_c, stall_c;

    scan_deser #(
        .WORD_W (WORD_W)
    ) u_deser (
        .clk     (CK),
        .rst_n   (RSTN),
        .clr     (clr_c),
        .sample  (sample_c),
        .so      (SCAN_SO),
        .ready   (DREADY),
        .dout    (DOUT),
        .dvalid  (DVALID),
        .stall_c (stall_c)
    );

    // Chain enable must react to back-pressure in the same cycle, so it stays combinational.
    assign SCAN_SP = sp_c;

    // Next-state and next-output decode.
    always_comb begin
        state_d  = state_q;
        fill_d   = fill_q;
        cnt_d    = cnt_q;
        sp_c     = 1'b0;
        sample_c = 1'b0;
        clr_c    = 1'b0;

        unique case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (START) begin
                    state_d = CAPTURE;
                    fill_d  = FILL;
                end
            end
            CAPTURE: begin
                sp_c    = 1'b1;
                clr_c   = 1'b1;
                cnt_d   = '0;
                state_d = SHIFT;
            end
            SHIFT: begin
                if (!stall_c) begin
                    sp_c     = 1'b1;
                    sample_c = 1'b1;
                    cnt_d    = cnt_q + CNT_W'(1);
                    if (cnt_q == LAST_CNT) begin
                        state_d = DRAIN;
                    end
                end
            end
            DRAIN: begin
                if (DVALID && DREADY) begin
                    state_d = FIN;
                end
            end
            FIN: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d == CAPTURE) || (state_d == SHIFT) || (state_d == DRAIN);
        // SD holds at scan until IDLE so a stall never reloads functional data.
        sd_d   = (state_d == SHIFT) || (state_d == DRAIN) || (state_d == FIN);
        si_d   = sd_d ? fill_d : 1'b0;
        done_d = (state_d == FIN);
    end

    always_ff @(posedge CK or negedge RSTN) begin
        if (!RSTN) begin
            state_q <= IDLE;
            fill_q  <= 1'b0;
            cnt_q   <= '0;
            BUSY    <= 1'b0;
            SCAN_SD <= 1'b0;
            SCAN_SI <= 1'b0;
            DONE    <= 1'b0;
        end else begin
            state_q <= state_d;
            fill_q  <= fill_d;
            cnt_q   <= cnt_d;
            BUSY    <= busy_d;
            SCAN_SD <= sd_d;
            SCAN_SI <= si_d;
            DONE    <= done_d;
        end
    end

endmodule

// File: tb/tb_scan_unload_ctrl.sv
// Bench for scan_unload_ctrl driving a 16-cell scan-mux chain model.
module tb_scan_unload_ctrl;

    localparam int CL     = 16;
    localparam int W      = 8;
    localparam int NW     = CL / W;
    localparam int BUDGET = 300;

    logic          CK;
    logic          RSTN;
    logic          START;
    logic          FILL;
    logic          DREADY;
    logic          BUSY;
    logic          SCAN_SD;
    logic          SCAN_SP;
    logic          SCAN_SI;
    logic          SCAN_SO;
    logic [W-1:0]  DOUT;
    logic          DVALID;
    logic          DONE;

    logic [CL-1:0] chain;
    logic [CL-1:0] d0_pat;

    int checks;
    int errors;

    logic [W-1:0] got[$];
    int done_cyc;
    int done_cnt;
    int sp_hi;
    int sd_bad;

    typedef struct {
        logic [CL-1:0] d0;
        logic          fill;
        int            mode;      // 0 ready, 1 stall burst, 2 toggle, 3 random
        int            stall_n;
        bit            rep;
        logic [W-1:0]  w0;
        logic [W-1:0]  w1;
        int            done_at;   // -1: not checked
        logic [CL-1:0] chain_after;
    } vec_t;

    vec_t vecs[5];

    scan_unload_ctrl #(
        .CHAIN_LEN (CL),
        .WORD_W    (W)
    ) dut (
        .CK      (CK),
        .RSTN    (RSTN),
        .START   (START),
        .FILL    (FILL),
        .BUSY    (BUSY),
        .SCAN_SD (SCAN_SD),
        .SCAN_SP (SCAN_SP),
        .SCAN_SI (SCAN_SI),
        .SCAN_SO (SCAN_SO),
        .DOUT    (DOUT),
        .DVALID  (DVALID),
        .DREADY  (DREADY),
        .DONE    (DONE)
    );

    initial CK = 1'b0;
    always #5 CK = ~CK;

    // Scan-mux flops: SD picks D1 (previous cell / SI) over D0, SP enables.
    assign SCAN_SO = chain[CL-1];
    always @(posedge CK) begin
        if (SCAN_SP) chain <= SCAN_SD ? {chain[CL-2:0], SCAN_SI} : d0_pat;
    end

    // Word j bit k carries cell CL-1-(j*W+k).
    function automatic logic [W-1:0] ref_word(input logic [CL-1:0] pat, input int j);
        logic [W-1:0] w;
        for (int k = 0; k < W; k++) w[k] = pat[CL-1-(j*W+k)];
        return w;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic run_unload(input logic [CL-1:0] pat, input logic fv, input int mode,
                              input int stall_n, input bit rep);
        bit saw_valid;
        bit released;
        int stalls;
        got.delete();
        done_cyc = -1;
        done_cnt = 0;
        sp_hi    = 0;
        sd_bad   = 0;
        saw_valid = 1'b0;
        released  = 1'b0;
        stalls    = 0;
        @(negedge CK);
        d0_pat = pat;
        FILL   = fv;
        DREADY = 1'b1;
        START  = 1'b1;
        for (int n = 1; n <= BUDGET; n++) begin
            @(negedge CK);
            START = rep ? (BUSY && n[0]) : 1'b0;
            if (DVALID) saw_valid = 1'b1;
            case (mode)
                1:       DREADY = !(saw_valid && !released);
                2:       DREADY = n[0];
                3:       DREADY = 1'($urandom_range(0, 1));
                default: DREADY = 1'b1;
            endcase
            #1;
            if (SCAN_SP) sp_hi++;
            if (BUSY && n >= 2 && !SCAN_SD) sd_bad++;
            if (mode == 1 && !released && !DREADY && BUSY && !SCAN_SP) begin
                stalls++;
                if (stalls >= stall_n) released = 1'b1;
            end
            if (DVALID && DREADY) got.push_back(DOUT);
            if (DONE) begin
                done_cnt++;
                if (done_cyc < 0) done_cyc = n;
            end
            if (done_cyc >= 0 && n >= done_cyc + 4) break;
        end
        START  = 1'b0;
        DREADY = 1'b1;
    endtask

    task automatic check_run(input string tag, input logic [W-1:0] ew0, input logic [W-1:0] ew1,
                             input int edone, input logic [CL-1:0] echain);
        check($sformatf("%s.nwords", tag), 32'(got.size()), 32'(NW));
        if (got.size() > 0) check($sformatf("%s.word0", tag), 32'(got[0]), 32'(ew0));
        if (got.size() > 1) check($sformatf("%s.word1", tag), 32'(got[1]), 32'(ew1));
        check($sformatf("%s.done_pulses", tag), 32'(done_cnt), 32'd1);
        if (edone >= 0) check($sformatf("%s.done_cycle", tag), 32'(done_cyc), 32'(edone));
        check($sformatf("%s.chain_after", tag), 32'(chain), 32'(echain));
        check($sformatf("%s.sp_cycles", tag), 32'(sp_hi), 32'(CL + 1));
        check($sformatf("%s.sd_low_while_busy", tag), 32'(sd_bad), 32'd0);
    endtask

    initial begin
        logic [CL-1:0] pat;
        logic          fv;
        int            mode;
        int            sn;
        int            dcnt;
        int            bcnt;

        checks = 0;
        errors = 0;
        RSTN   = 1'b0;
        START  = 1'b0;
        FILL   = 1'b0;
        DREADY = 1'b1;
        d0_pat = '0;

        vecs[0] = '{16'hA5C3, 1'b0, 0, 0, 1'b0, 8'hA5, 8'hC3, 19, 16'h0000};
        vecs[1] = '{16'h0000, 1'b1, 0, 0, 1'b0, 8'h00, 8'h00, 19, 16'hFFFF};
        vecs[2] = '{16'h1234, 1'b0, 1, 5, 1'b0, 8'h48, 8'h2C, 24, 16'h0000};
        vecs[3] = '{16'h8001, 1'b1, 0, 0, 1'b1, 8'h01, 8'h80, 19, 16'hFFFF};
        vecs[4] = '{16'hF00F, 1'b0, 2, 0, 1'b0, 8'h0F, 8'hF0, -1, 16'h0000};

        repeat (2) @(negedge CK);
        check("reset.busy", 32'(BUSY), 32'd0);
        check("reset.sd", 32'(SCAN_SD), 32'd0);
        check("reset.sp", 32'(SCAN_SP), 32'd0);
        check("reset.si", 32'(SCAN_SI), 32'd0);
        check("reset.dvalid", 32'(DVALID), 32'd0);
        check("reset.done", 32'(DONE), 32'd0);
        check("reset.dout", 32'(DOUT), 32'd0);
        RSTN = 1'b1;

        for (int i = 0; i < 5; i++) begin
            run_unload(vecs[i].d0, vecs[i].fill, vecs[i].mode, vecs[i].stall_n, vecs[i].rep);
            check_run($sformatf("vec%0d", i), vecs[i].w0, vecs[i].w1, vecs[i].done_at,
                      vecs[i].chain_after);
        end
        repeat (4) @(negedge CK);
        check("rep.idle_after", 32'(BUSY), 32'd0);

        // Abort after six shifted bits: chain must keep its partial contents.
        @(negedge CK);
        d0_pat = 16'hA5C3;
        FILL   = 1'b1;
        START  = 1'b1;
        for (int n = 1; n <= 8; n++) begin
            @(negedge CK);
            START = 1'b0;
        end
        check("abort.busy_before", 32'(BUSY), 32'd1);
        RSTN = 1'b0;
        #1;
        check("abort.busy", 32'(BUSY), 32'd0);
        check("abort.sd", 32'(SCAN_SD), 32'd0);
        check("abort.sp", 32'(SCAN_SP), 32'd0);
        check("abort.si", 32'(SCAN_SI), 32'd0);
        check("abort.dvalid", 32'(DVALID), 32'd0);
        check("abort.dout", 32'(DOUT), 32'd0);
        pat = (16'hA5C3 << 6) | 16'h003F;
        dcnt = 0;
        bcnt = 0;
        repeat (3) begin
            @(negedge CK);
            if (DONE) dcnt++;
            if (BUSY) bcnt++;
        end
        check("abort.chain_kept", 32'(chain), 32'(pat));
        check("abort.no_done", 32'(dcnt), 32'd0);
        check("abort.no_busy", 32'(bcnt), 32'd0);
        RSTN = 1'b1;
        run_unload(16'hA5C3, 1'b0, 0, 0, 1'b0);
        check_run("rerun", 8'hA5, 8'hC3, 19, 16'h0000);

        // Random patterns and back-pressure against the reference ordering.
        for (int r = 0; r < 12; r++) begin
            pat  = CL'($urandom);
            fv   = 1'($urandom_range(0, 1));
            mode = $urandom_range(0, 3);
            sn   = $urandom_range(1, 6);
            run_unload(pat, fv, mode, sn, 1'b0);
            check_run($sformatf("rand%0d", r), ref_word(pat, 0), ref_word(pat, 1),
                      (mode == 0) ? CL + 3 : ((mode == 1) ? CL + 3 + sn : -1),
                      fv ? {CL{1'b1}} : {CL{1'b0}});
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
